// File: rtl/switch_node_4rad_alloc.sv
// Radix-4 butterfly switch node: per-output round-robin allocation with wormhole
// locking, valid/ready inputs and registered output slots.
module switch_node_4rad_alloc #(
    parameter int CHANNEL_WIDTH = 18,
    parameter int DEST_LSB      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    in_valid,
    input  logic [3:0][CHANNEL_WIDTH-1:0] in_ch,
    output logic [3:0]                    in_ready,
    output logic [3:0]                    out_valid,
    output logic [3:0][CHANNEL_WIDTH-1:0] out_ch,
    input  logic [3:0]                    out_ready,
    output logic                          err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state      [4];
    state_t     state_next [4];
    logic [1:0] owner      [4];
    logic [1:0] owner_next [4];
    logic [1:0] rr_ptr     [4];
    logic [1:0] rr_next    [4];
    logic [3:0] released;
    logic [3:0] released_next;

    logic [3:0] head;
    logic [3:0] tail;
    logic [1:0] dest       [4];
    logic [3:0] in_locked;
    logic [1:0] lock_dst   [4];
    logic [3:0] can_load;
    logic [3:0] req        [4];
    logic [1:0] win        [4];
    logic [3:0] grant;
    logic [3:0] load;
    logic [CHANNEL_WIDTH-1:0] load_data [4];
    logic       err_next;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            head[i]     = in_ch[i][CHANNEL_WIDTH-1];
            tail[i]     = in_ch[i][CHANNEL_WIDTH-2];
            dest[i]     = in_ch[i][DEST_LSB +: 2];
            in_locked[i] = 1'b0;
            lock_dst[i]  = 2'd0;
            for (int o = 0; o < 4; o++) begin
                if (state[o] == LOCKED && owner[o] == 2'(i)) begin
                    in_locked[i] = 1'b1;
                    lock_dst[i]  = 2'(o);
                end
            end
        end
        for (int o = 0; o < 4; o++) begin
            can_load[o] = !out_valid[o] || out_ready[o];
        end
    end

    // An input released on a tail this cycle may not request again until the next one.
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            req[o]   = '0;
            win[o]   = rr_ptr[o];
            grant[o] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                req[o][i] = in_valid[i] && head[i] && (dest[i] == 2'(o)) &&
                            !in_locked[i] && !released[i] && (state[o] == IDLE);
            end
            for (int k = 3; k >= 0; k--) begin
                if (req[o][rr_ptr[o] + 2'(k)]) begin
                    win[o] = rr_ptr[o] + 2'(k);
                end
            end
            grant[o] = (|req[o]) && can_load[o];
        end
    end

    always_comb begin
        released_next = '0;
        for (int o = 0; o < 4; o++) begin
            state_next[o] = state[o];
            owner_next[o] = owner[o];
            rr_next[o]    = rr_ptr[o];
            case (state[o])
                IDLE: begin
                    if (grant[o]) begin
                        rr_next[o] = win[o] + 2'd1;
                        if (!tail[win[o]]) begin
                            state_next[o] = LOCKED;
                            owner_next[o] = win[o];
                        end
                    end
                end
                LOCKED: begin
                    if (in_valid[owner[o]] && can_load[o] && tail[owner[o]]) begin
                        state_next[o]           = IDLE;
                        released_next[owner[o]] = 1'b1;
                    end
                end
                default: state_next[o] = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_locked[i]) begin
                in_ready[i] = can_load[lock_dst[i]];
            end else if (in_valid[i] && !head[i]) begin
                in_ready[i] = 1'b1;
            end else if (in_valid[i] && head[i] && grant[dest[i]] && win[dest[i]] == 2'(i)) begin
                in_ready[i] = 1'b1;
            end
        end
        for (int o = 0; o < 4; o++) begin
            if (state[o] == LOCKED) begin
                load[o]      = in_valid[owner[o]] && can_load[o];
                load_data[o] = in_ch[owner[o]];
            end else begin
                load[o]      = grant[o];
                load_data[o] = in_ch[win[o]];
            end
        end
        err_next = (|(in_valid & ~head & ~in_locked)) ||
                   (|(in_valid & in_ready & head & in_locked));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < 4; o++) begin
                state[o]     <= IDLE;
                owner[o]     <= 2'd0;
                rr_ptr[o]    <= 2'd0;
                out_valid[o] <= 1'b0;
                out_ch[o]    <= '0;
            end
            released <= '0;
            err      <= 1'b0;
        end else begin
            for (int o = 0; o < 4; o++) begin
                state[o]  <= state_next[o];
                owner[o]  <= owner_next[o];
                rr_ptr[o] <= rr_next[o];
                if (load[o]) begin
                    out_valid[o] <= 1'b1;
                    out_ch[o]    <= load_data[o];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            released <= released_next;
            err      <= err_next;
        end
    end

endmodule

// File: tb/tb_switch_node_4rad_alloc.sv
// Table-driven bench for switch_node_4rad_alloc: per-cycle vectors plus a
// per-output scoreboard of expected flits.
module tb_switch_node_4rad_alloc;

    localparam int W = 18;

    logic                clk;
    logic                rst;
    logic [3:0]          in_valid;
    logic [3:0][W-1:0]   in_ch;
    logic [3:0]          in_ready;
    logic [3:0]          out_valid;
    logic [3:0][W-1:0]   out_ch;
    logic [3:0]          out_ready;
    logic                err;

    switch_node_4rad_alloc #(.CHANNEL_WIDTH(W), .DEST_LSB(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic [3:0]        valid;
        logic [3:0][W-1:0] ch;
        logic [3:0]        oready;
        logic [3:0]        exp_ready;
        logic [3:0]        push_mask;
        logic [3:0][1:0]   push_src;
        logic [3:0]        exp_ovalid;
        logic              exp_err;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb [4][$];
    int           n_cmp;
    int           n_fail;

    function automatic logic [W-1:0] mk(input logic h, input logic t,
                                        input logic [1:0] d, input logic [7:0] tag);
        return {h, t, 6'd0, tag, d};
    endfunction

    task automatic add_vec(input logic r, input logic [3:0] valid,
                           input logic [W-1:0] c0, input logic [W-1:0] c1,
                           input logic [W-1:0] c2, input logic [W-1:0] c3,
                           input logic [3:0] oready, input logic [3:0] exp_ready,
                           input logic [3:0] push_mask, input logic [7:0] push_src,
                           input logic [3:0] exp_ovalid, input logic exp_err);
        vec_t v;
        v.rst        = r;
        v.valid      = valid;
        v.ch[0]      = c0;
        v.ch[1]      = c1;
        v.ch[2]      = c2;
        v.ch[3]      = c3;
        v.oready     = oready;
        v.exp_ready  = exp_ready;
        v.push_mask  = push_mask;
        v.push_src   = push_src;
        v.exp_ovalid = exp_ovalid;
        v.exp_err    = exp_err;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_vec(input logic [3:0] exp_ovalid);
        add_vec(0, 4'b0000, '0, '0, '0, '0, 4'hF, 4'b0000, 4'b0000, 8'h00, exp_ovalid, 0);
    endtask

    task automatic build_vectors();
        idle_vec(4'b0000);
        // round robin: inputs 0,1,2 keep single-flit packets toward output 2
        add_vec(0, 4'b0111, mk(1,1,2,8'h01), mk(1,1,2,8'h02), mk(1,1,2,8'h03), '0, 4'hF, 4'b0001, 4'b0100, {2'd0,2'd0,2'd0,2'd0}, 4'b0100, 0);
        add_vec(0, 4'b0111, mk(1,1,2,8'h04), mk(1,1,2,8'h02), mk(1,1,2,8'h03), '0, 4'hF, 4'b0010, 4'b0100, {2'd0,2'd1,2'd0,2'd0}, 4'b0100, 0);
        add_vec(0, 4'b0111, mk(1,1,2,8'h04), mk(1,1,2,8'h05), mk(1,1,2,8'h03), '0, 4'hF, 4'b0100, 4'b0100, {2'd0,2'd2,2'd0,2'd0}, 4'b0100, 0);
        add_vec(0, 4'b0111, mk(1,1,2,8'h04), mk(1,1,2,8'h05), mk(1,1,2,8'h06), '0, 4'hF, 4'b0001, 4'b0100, {2'd0,2'd0,2'd0,2'd0}, 4'b0100, 0);
        add_vec(0, 4'b0111, mk(1,1,2,8'h07), mk(1,1,2,8'h05), mk(1,1,2,8'h06), '0, 4'hF, 4'b0010, 4'b0100, {2'd0,2'd1,2'd0,2'd0}, 4'b0100, 0);
        add_vec(0, 4'b0111, mk(1,1,2,8'h07), mk(1,1,2,8'h08), mk(1,1,2,8'h06), '0, 4'hF, 4'b0100, 4'b0100, {2'd0,2'd2,2'd0,2'd0}, 4'b0100, 0);
        idle_vec(4'b0000);
        // four independent single-flit packets in one cycle
        add_vec(0, 4'b1111, mk(1,1,0,8'h10), mk(1,1,1,8'h11), mk(1,1,2,8'h12), mk(1,1,3,8'h13), 4'hF, 4'b1111, 4'b1111, {2'd3,2'd2,2'd1,2'd0}, 4'b1111, 0);
        idle_vec(4'b0000);
        // wormhole: input 3 holds output 1 for four flits while input 0 waits
        add_vec(0, 4'b1001, mk(1,1,1,8'h20), '0, '0, mk(1,0,1,8'h21), 4'hF, 4'b1000, 4'b0010, {2'd0,2'd0,2'd3,2'd0}, 4'b0010, 0);
        add_vec(0, 4'b1001, mk(1,1,1,8'h20), '0, '0, mk(0,0,0,8'h22), 4'hF, 4'b1000, 4'b0010, {2'd0,2'd0,2'd3,2'd0}, 4'b0010, 0);
        add_vec(0, 4'b1001, mk(1,1,1,8'h20), '0, '0, mk(0,0,0,8'h23), 4'hF, 4'b1000, 4'b0010, {2'd0,2'd0,2'd3,2'd0}, 4'b0010, 0);
        add_vec(0, 4'b1001, mk(1,1,1,8'h20), '0, '0, mk(0,1,0,8'h24), 4'hF, 4'b1000, 4'b0010, {2'd0,2'd0,2'd3,2'd0}, 4'b0010, 0);
        add_vec(0, 4'b0001, mk(1,1,1,8'h20), '0, '0, '0, 4'hF, 4'b0001, 4'b0010, {2'd0,2'd0,2'd0,2'd0}, 4'b0010, 0);
        idle_vec(4'b0000);
        // backpressure on output 1 for three cycles mid-packet
        add_vec(0, 4'b0100, '0, '0, mk(1,0,1,8'h30), '0, 4'hF, 4'b0100, 4'b0010, {2'd0,2'd0,2'd2,2'd0}, 4'b0010, 0);
        add_vec(0, 4'b0100, '0, '0, mk(0,0,0,8'h31), '0, 4'b1101, 4'b0000, 4'b0000, 8'h00, 4'b0010, 0);
        add_vec(0, 4'b0100, '0, '0, mk(0,0,0,8'h31), '0, 4'b1101, 4'b0000, 4'b0000, 8'h00, 4'b0010, 0);
        add_vec(0, 4'b0100, '0, '0, mk(0,0,0,8'h31), '0, 4'b1101, 4'b0000, 4'b0000, 8'h00, 4'b0010, 0);
        add_vec(0, 4'b0100, '0, '0, mk(0,0,0,8'h31), '0, 4'hF, 4'b0100, 4'b0010, {2'd0,2'd0,2'd2,2'd0}, 4'b0010, 0);
        add_vec(0, 4'b0100, '0, '0, mk(0,0,0,8'h32), '0, 4'hF, 4'b0100, 4'b0010, {2'd0,2'd0,2'd2,2'd0}, 4'b0010, 0);
        add_vec(0, 4'b0100, '0, '0, mk(0,1,0,8'h33), '0, 4'hF, 4'b0100, 4'b0010, {2'd0,2'd0,2'd2,2'd0}, 4'b0010, 0);
        idle_vec(4'b0000);
        // body flit on an unlocked input is swallowed and flagged once
        add_vec(0, 4'b0010, '0, mk(0,0,0,8'h40), '0, '0, 4'hF, 4'b0010, 4'b0000, 8'h00, 4'b0000, 1);
        idle_vec(4'b0000);
        // head flit inside a packet is forwarded and flagged
        add_vec(0, 4'b0001, mk(1,0,3,8'h50), '0, '0, '0, 4'hF, 4'b0001, 4'b1000, {2'd0,2'd0,2'd0,2'd0}, 4'b1000, 0);
        add_vec(0, 4'b0001, mk(1,0,0,8'h51), '0, '0, '0, 4'hF, 4'b0001, 4'b1000, {2'd0,2'd0,2'd0,2'd0}, 4'b1000, 1);
        add_vec(0, 4'b0001, mk(0,1,0,8'h52), '0, '0, '0, 4'hF, 4'b0001, 4'b1000, {2'd0,2'd0,2'd0,2'd0}, 4'b1000, 0);
        idle_vec(4'b0000);
        // release on tail, then a different input takes output 0 next cycle
        add_vec(0, 4'b0010, '0, mk(1,0,0,8'h60), '0, '0, 4'hF, 4'b0010, 4'b0001, {2'd0,2'd0,2'd0,2'd1}, 4'b0001, 0);
        add_vec(0, 4'b0110, '0, mk(0,1,0,8'h61), mk(1,1,0,8'h62), '0, 4'hF, 4'b0010, 4'b0001, {2'd0,2'd0,2'd0,2'd1}, 4'b0001, 0);
        add_vec(0, 4'b0110, '0, mk(1,1,0,8'h63), mk(1,1,0,8'h62), '0, 4'hF, 4'b0100, 4'b0001, {2'd0,2'd0,2'd0,2'd2}, 4'b0001, 0);
        add_vec(0, 4'b0010, '0, mk(1,1,0,8'h63), '0, '0, 4'hF, 4'b0010, 4'b0001, {2'd0,2'd0,2'd0,2'd1}, 4'b0001, 0);
        idle_vec(4'b0000);
        // reset in the middle of a packet
        add_vec(0, 4'b0001, mk(1,0,2,8'h70), '0, '0, '0, 4'hF, 4'b0001, 4'b0100, {2'd0,2'd0,2'd0,2'd0}, 4'b0100, 0);
        add_vec(1, 4'b0000, '0, '0, '0, '0, 4'h0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);
        add_vec(0, 4'b0001, mk(1,1,2,8'h71), '0, '0, '0, 4'hF, 4'b0001, 4'b0100, {2'd0,2'd0,2'd0,2'd0}, 4'b0100, 0);
        idle_vec(4'b0000);
    endtask

    task automatic apply_stimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        rst       = v.rst;
        in_valid  = v.valid;
        in_ch     = v.ch;
        out_ready = v.oready;
        #1;
        for (int o = 0; o < 4; o++) begin
            if (out_valid[o]) begin
                if (sb[o].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL v%0d unexpected_flit out%0d: got %0h expected none", idx, o, out_ch[o]);
                end else begin
                    check_output($sformatf("v%0d out_ch[%0d]", idx, o), 32'(out_ch[o]), 32'(sb[o][0]));
                    if (out_ready[o]) void'(sb[o].pop_front());
                end
            end
        end
        check_output($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_ready));
        for (int o = 0; o < 4; o++) begin
            if (v.push_mask[o]) sb[o].push_back(v.ch[v.push_src[o]]);
        end
        @(posedge clk);
        #1;
        check_output($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_ovalid));
        check_output($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
        if (v.rst) begin
            for (int o = 0; o < 4; o++) sb[o].delete();
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = '0;
        in_ch     = '0;
        out_ready = 4'hF;
        build_vectors();

        repeat (2) @(posedge clk);
        #1;
        check_output("reset out_valid", 32'(out_valid), 32'h0);
        check_output("reset err", 32'(err), 32'h0);
        check_output("reset in_ready", 32'(in_ready), 32'h0);

        for (int idx = 0; idx < vecs.size(); idx++) begin
            apply_stimulus(idx);
        end

        for (int o = 0; o < 4; o++) begin
            check_output($sformatf("leftover flits out%0d", o), 32'(sb[o].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_node_4rad_alloc.md
Name: switch_node_4rad_alloc

Overview:
Output-port allocator and flow-control front end for one radix-4 switch node of the 64-port, 3-layer symmetrical butterfly. Accepts up to 4 input flit streams with valid/ready handshakes and decodes a 2-bit destination digit from each head flit. Grants each output to one input at a time, using per-output round-robin arbitration and wormhole locking until the tail flit. Drives registered outputs toward the inter-layer crossbar; one instance per node, with DEST_LSB set per layer.

Parameters:
CHANNEL_WIDTH, 18, flit width; bit CHANNEL_WIDTH-1 = head, bit CHANNEL_WIDTH-2 = tail, remaining bits = payload
DEST_LSB, 0, LSB position within the head-flit payload of the 2-bit destination digit for this layer (layer 1/2/3 use 4/2/0)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  4  per-input flit valid
in_ch  input  [4][CHANNEL_WIDTH]  per-input flit
in_ready  output  4  per-input accept; combinational
out_valid  output  4  per-output flit valid; registered
out_ch  output  [4][CHANNEL_WIDTH]  per-output flit; registered
out_ready  input  4  downstream accept per output
err  output  1  one-cycle pulse on protocol violation; registered

Behaviour:
- Single clock clk; reset is synchronous and active-high on rst.
- Reset values: out_valid=0, out_ch=0, err=0, all outputs IDLE, all rr_ptr=0, all input locks cleared.
- Reset mid-packet discards held output flits and drops all locks; the next flit on any input must be a head flit.
- Transfer rules:
  - Input transfer: in_valid[i] && in_ready[i]. Output transfer: out_valid[o] && out_ready[o].
  - Output slot o can load when !out_valid[o] || out_ready[o].
  - A loaded flit appears on out_ch[o] the next cycle, so latency is exactly 1 cycle.
  - With continuous out_ready, an output sustains 1 flit/cycle.
- Destination: dest = in_ch[i][DEST_LSB+1:DEST_LSB], decoded only on head flits from unlocked inputs.
- Per-output FSM:
  - IDLE: requesters are inputs with in_valid, head=1, dest=o and no current lock.
  - The winner is the first requester scanning from rr_ptr[o] upward, mod 4.
  - Grant occurs only in a cycle where slot o can load; the grant and the head-flit transfer happen in the same cycle.
  - On grant, rr_ptr[o] := winner+1 mod 4.
  - If the granted flit also has tail=1 (single-flit packet), the output stays IDLE. Otherwise it goes to LOCKED(owner=winner) and input winner is locked to o.
  - LOCKED(k): in_ready[k] = slot o can load; each transferred flit is forwarded unchanged.
  - On transfer of a tail flit, the output returns to IDLE next cycle and input k is unlocked; the output can be re-granted that next cycle.
- in_ready[i] = 0 for losing requesters and for locked inputs whose output slot is blocked.
- Protocol errors (err=1 the following cycle):
  - Non-head flit on an unlocked input: consumed (in_ready=1) and dropped.
  - Head flit on a locked input: forwarded as a normal flit of the current packet.
- Inputs with no request have in_ready=0, except in the drop case above.
- Simultaneous events: one output can release on tail and load a new head in the same cycle only if the head comes from a different, already-unlocked input; the released input's own next head waits one cycle. Different outputs arbitrate independently, so up to 4 transfers per cycle.
- Backpressure: while out_ready[o]=0 and out_valid[o]=1, out_ch[o] holds stable and rr_ptr[o] does not advance.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, err=0, in_ready=0 for all inputs.
- Single-flit packets: inputs 0..3 each send head+tail, dest=0..3 respectively, out_ready=4'hF -> each appears on its out_ch one cycle later, 4 transfers in one cycle.
- Round-robin contention: inputs 0,1,2 continuously send single-flit packets to dest 2 -> grant order 0,1,2,0,1,2, rr_ptr[2] cycling 1,2,0.
- Wormhole lock: input 3 sends a 4-flit packet (head, body, body, tail) to dest 1 while input 0 requests dest 1 -> input 0 is held off for 4 cycles, then granted the cycle after the tail; flits are not interleaved.
- Backpressure: out_ready[1]=0 for 3 cycles mid-packet -> out_ch[1] held stable, in_ready of the owner is 0, no flit is lost or duplicated after release.
- Errors and reset: body flit on an unlocked input -> dropped, err pulses once. Assert rst mid-packet -> out_valid=0 next cycle, and a new head on any input is granted normally afterwards.
